regbank_writeback_sequencer: RTL and testbench

- Write-side driver for the 32x32 register bank; produces its RegWrite/writeAdd/writeData/highData/raDataIn inputs.
- Accepts writeback requests from execute over a valid/ready handshake and buffers them in a small FIFO.
- Issues at most one bank write per cycle and suppresses writes to $zero.
- Reports whether a read address has an uncommitted write outstanding, so decode can stall.

---
 rtl/regbank_writeback_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_regbank_writeback_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_writeback_sequencer.sv
// regbank_writeback_sequencer
//   Write-side driver for the 32x32 register bank. Writeback requests from
//   execute arrive over a valid/ready handshake. Non-dropped requests queue
//   in a small FIFO and feed a registered output slot that drives the bank
//   write ports, one write per cycle. Writes to $zero and no-op requests are
//   accepted and discarded. pendA/pendB tell decode whether a read address
//   still has a write in flight, so decode can stall.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   req_valid/req_ready   request handshake (ready = count < DEPTH)
//   req_kind              01 single, 10 mult hi/lo, 11 $ra write, 00 no-op
//   req_add/req_lo/req_hi request address and data words
//   RegWrite..raDataIn    bank write interface (registered output slot)
//   chk_addA/chk_addB     decode read addresses to check for hazards
//   pendA/pendB           a write to that address is still outstanding
//   count                 valid FIFO entries, excluding the output slot
module regbank_writeback_sequencer #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_kind,
  input  logic [4:0]       req_add,
  input  logic [31:0]      req_lo,
  input  logic [31:0]      req_hi,
  output logic [1:0]       RegWrite,
  output logic [4:0]       writeAdd,
  output logic [31:0]      writeData,
  output logic [31:0]      highData,
  output logic [31:0]      raDataIn,
  input  logic [4:0]       chk_addA,
  input  logic [4:0]       chk_addB,
  output logic             pendA,
  output logic             pendB,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [1:0] KIND_NOP  = 2'b00;
  localparam logic [1:0] KIND_ONE  = 2'b01;
  localparam logic [1:0] KIND_MULT = 2'b10;
  localparam logic [1:0] KIND_RA   = 2'b11;

  // FIFO storage holds the raw request; field mapping happens on the way
  // into the output slot.
  logic [1:0]       r_kind [DEPTH];
  logic [4:0]       r_add  [DEPTH];
  logic [31:0]      r_lo   [DEPTH];
  logic [31:0]      r_hi   [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  // Output slot
  logic [1:0]       r_reg_write;
  logic [4:0]       r_write_add;
  logic [31:0]      r_write_data;
  logic [31:0]      r_high_data;
  logic [31:0]      r_ra_data;

  logic             w_accept;
  logic             w_drop;
  logic             w_nonempty;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_src_kind;
  logic [4:0]       w_src_add;
  logic [31:0]      w_src_lo;
  logic [31:0]      w_src_hi;
  logic             w_pend_a;
  logic             w_pend_b;

  // True when a write of this kind/address would target chk. Kind 10 writes
  // hi/lo (registers 19 and 20); kind 11 always writes $ra.
  function automatic logic hits(input logic [1:0] kind, input logic [4:0] add,
                                input logic [4:0] chk);
    logic hit;
    hit = 1'b0;
    case (kind)
      KIND_ONE:  hit = (add == chk);
      KIND_MULT: hit = (chk == 5'd19) || (chk == 5'd20);
      KIND_RA:   hit = (chk == 5'd31);
      default:   hit = 1'b0;
    endcase
    return hit && (chk != 5'd0);
  endfunction

  assign req_ready  = (r_count < CNT_W'(DEPTH));
  assign w_accept   = req_valid && req_ready;
  assign w_drop     = (req_kind == KIND_NOP) ||
                      ((req_kind == KIND_ONE) && (req_add == 5'd0));
  assign w_nonempty = (r_count != '0);
  // With the FIFO empty an accepted request bypasses straight to the slot,
  // so it only enters the FIFO when something is already queued ahead of it.
  assign w_push     = w_accept && !w_drop && w_nonempty;
  assign w_pop      = w_nonempty;

  // Source for the next slot contents: FIFO head, bypassed request, or idle.
  always_comb begin
    w_src_kind = KIND_NOP;
    w_src_add  = '0;
    w_src_lo   = '0;
    w_src_hi   = '0;
    if (w_nonempty) begin
      w_src_kind = r_kind[r_rd_ptr];
      w_src_add  = r_add[r_rd_ptr];
      w_src_lo   = r_lo[r_rd_ptr];
      w_src_hi   = r_hi[r_rd_ptr];
    end else if (w_accept && !w_drop) begin
      w_src_kind = req_kind;
      w_src_add  = req_add;
      w_src_lo   = req_lo;
      w_src_hi   = req_hi;
    end
  end

  // NOTE: storage arrays carry no reset; r_count alone decides which entries
  // are meaningful, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_kind[r_wr_ptr] <= req_kind;
      r_add[r_wr_ptr]  <= req_add;
      r_lo[r_wr_ptr]   <= req_lo;
      r_hi[r_wr_ptr]   <= req_hi;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_reg_write  <= KIND_NOP;
      r_write_add  <= '0;
      r_write_data <= '0;
      r_high_data  <= '0;
      r_ra_data    <= '0;
    end else begin
      // Pointers are PTR_W wide and DEPTH is a power of 2, so they wrap.
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);

      r_reg_write  <= w_src_kind;
      r_write_add  <= '0;
      r_write_data <= '0;
      r_high_data  <= '0;
      r_ra_data    <= '0;
      case (w_src_kind)
        KIND_ONE: begin
          r_write_add  <= w_src_add;
          r_write_data <= w_src_lo;
        end
        KIND_MULT: begin
          r_write_data <= w_src_lo;
          r_high_data  <= w_src_hi;
        end
        KIND_RA: begin
          r_write_add <= 5'd31;
          r_ra_data   <= w_src_lo;
        end
        default: ;
      endcase
    end
  end

  // Hazard detection over the output slot plus every live FIFO entry. An
  // entry is live when its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] offset;
    w_pend_a = hits(r_reg_write, r_write_add, chk_addA);
    w_pend_b = hits(r_reg_write, r_write_add, chk_addB);
    for (int i = 0; i < DEPTH; i++) begin
      offset = PTR_W'(i) - r_rd_ptr;
      if (CNT_W'(offset) < r_count) begin
        if (hits(r_kind[i], r_add[i], chk_addA)) w_pend_a = 1'b1;
        if (hits(r_kind[i], r_add[i], chk_addB)) w_pend_b = 1'b1;
      end
    end
  end

  assign pendA     = w_pend_a;
  assign pendB     = w_pend_b;
  assign count     = r_count;
  assign RegWrite  = r_reg_write;
  assign writeAdd  = r_write_add;
  assign writeData = r_write_data;
  assign highData  = r_high_data;
  assign raDataIn  = r_ra_data;

endmodule

// File: tb/tb_regbank_writeback_sequencer.sv
// Self-checking bench for regbank_writeback_sequencer. A queue-based model
// tracks the requests still to be written and the write currently presented
// to the bank; every cycle the DUT outputs are compared against it, plus
// fixed expectations for the directed scenarios.
module tb_regbank_writeback_sequencer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_kind;
  logic [4:0]       req_add;
  logic [31:0]      req_lo;
  logic [31:0]      req_hi;
  logic [1:0]       RegWrite;
  logic [4:0]       writeAdd;
  logic [31:0]      writeData;
  logic [31:0]      highData;
  logic [31:0]      raDataIn;
  logic [4:0]       chk_addA;
  logic [4:0]       chk_addB;
  logic             pendA;
  logic             pendB;
  logic [CNT_W-1:0] count;

  regbank_writeback_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_kind  (req_kind),
    .req_add   (req_add),
    .req_lo    (req_lo),
    .req_hi    (req_hi),
    .RegWrite  (RegWrite),
    .writeAdd  (writeAdd),
    .writeData (writeData),
    .highData  (highData),
    .raDataIn  (raDataIn),
    .chk_addA  (chk_addA),
    .chk_addB  (chk_addB),
    .pendA     (pendA),
    .pendB     (pendB),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  add;
    logic [31:0] lo;
    logic [31:0] hi;
  } req_t;

  req_t m_q[$];   // accepted, not yet presented to the bank
  req_t m_slot;   // write presented to the bank this cycle

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic req_t idle_req();
    req_t r;
    r.kind = 2'b00; r.add = 5'd0; r.lo = 32'd0; r.hi = 32'd0;
    return r;
  endfunction

  // Registers a write of this request will modify.
  function automatic logic targets(input req_t r, input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (r.kind == 2'b01) return r.add == a;
    if (r.kind == 2'b10) return (a == 5'd19) || (a == 5'd20);
    if (r.kind == 2'b11) return a == 5'd31;
    return 1'b0;
  endfunction

  function automatic logic model_pend(input logic [4:0] a);
    logic p;
    p = targets(m_slot, a);
    foreach (m_q[i]) if (targets(m_q[i], a)) p = 1'b1;
    return p;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_slot = idle_req();
  endtask

  task automatic compare_all();
    logic [4:0]  e_add;
    logic [31:0] e_data, e_hi, e_ra;
    e_add = 5'd0; e_data = 32'd0; e_hi = 32'd0; e_ra = 32'd0;
    case (m_slot.kind)
      2'b01: begin e_add = m_slot.add; e_data = m_slot.lo; end
      2'b10: begin e_data = m_slot.lo; e_hi = m_slot.hi; end
      2'b11: begin e_add = 5'd31; e_ra = m_slot.lo; end
      default: ;
    endcase
    check("RegWrite",  32'(RegWrite),  32'(m_slot.kind));
    check("writeAdd",  32'(writeAdd),  32'(e_add));
    check("writeData", writeData,      e_data);
    check("highData",  highData,       e_hi);
    check("raDataIn",  raDataIn,       e_ra);
    check("count",     32'(count),     32'(m_q.size()));
    check("req_ready", 32'(req_ready), 32'(m_q.size() < DEPTH));
    check("pendA",     32'(pendA),     32'(model_pend(chk_addA)));
    check("pendB",     32'(pendB),     32'(model_pend(chk_addB)));
  endtask

  // One clock cycle: drive inputs at the falling edge, compare the outputs of
  // the current cycle, then advance the model across the next rising edge.
  task automatic cycle(input logic v, input logic [1:0] k, input logic [4:0] a,
                       input logic [31:0] lo, input logic [31:0] hi,
                       input logic [4:0] ca, input logic [4:0] cb);
    req_t r;
    logic acc;
    @(negedge clk);
    req_valid = v; req_kind = k; req_add = a; req_lo = lo; req_hi = hi;
    chk_addA = ca; chk_addB = cb;
    #1;
    compare_all();
    r.kind = k; r.add = a; r.lo = lo; r.hi = hi;
    acc = v && (m_q.size() < DEPTH) && (k != 2'b00) && !(k == 2'b01 && a == 5'd0);
    if (m_q.size() > 0) begin
      m_slot = m_q.pop_front();
      if (acc) m_q.push_back(r);
    end else if (acc) begin
      m_slot = r;
    end else begin
      m_slot = idle_req();
    end
  endtask

  task automatic idle(input logic [4:0] ca, input logic [4:0] cb);
    cycle(1'b0, 2'b00, 5'd0, 32'd0, 32'd0, ca, cb);
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_kind = 2'b00; req_add = 5'd0;
    req_lo = 32'd0; req_hi = 32'd0; chk_addA = 5'd31; chk_addB = 5'd5;
    model_reset();

    // Reset state
    #12;
    check("rst_RegWrite",  32'(RegWrite), 32'd0);
    check("rst_count",     32'(count),    32'd0);
    check("rst_ready",     32'(req_ready), 32'd1);
    check("rst_pendA",     32'(pendA),    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single request
    cycle(1'b1, 2'b01, 5'd5, 32'hDEADBEEF, 32'h0, 5'd5, 5'd6);
    idle(5'd5, 5'd6);
    check("single_kind", 32'(RegWrite), 32'd1);
    check("single_add",  32'(writeAdd), 32'd5);
    check("single_data", writeData, 32'hDEADBEEF);
    check("single_hi",   highData, 32'd0);
    check("single_pend", 32'(pendA), 32'd1);
    idle(5'd5, 5'd6);
    check("single_done", 32'(RegWrite), 32'd0);

    // Mult plus hazard
    cycle(1'b1, 2'b10, 5'd7, 32'h11, 32'h22, 5'd19, 5'd20);
    idle(5'd19, 5'd20);
    check("mult_kind",  32'(RegWrite), 32'd2);
    check("mult_lo",    writeData, 32'h11);
    check("mult_hi",    highData,  32'h22);
    check("mult_add",   32'(writeAdd), 32'd0);
    check("mult_pendA", 32'(pendA), 32'd1);
    check("mult_pendB", 32'(pendB), 32'd1);
    idle(5'd19, 5'd20);
    check("mult_clrA",  32'(pendA), 32'd0);
    check("mult_clrB",  32'(pendB), 32'd0);

    // Zero suppression
    cycle(1'b1, 2'b01, 5'd0, 32'h55, 32'h0, 5'd0, 5'd0);
    check("zero_ready", 32'(req_ready), 32'd1);
    cycle(1'b1, 2'b00, 5'd9, 32'h66, 32'h0, 5'd0, 5'd9);
    check("zero_kind",  32'(RegWrite), 32'd0);
    check("nop_ready",  32'(req_ready), 32'd1);
    idle(5'd0, 5'd9);
    check("nop_kind",   32'(RegWrite), 32'd0);
    check("nop_count",  32'(count), 32'd0);
    check("zero_pendA", 32'(pendA), 32'd0);
    check("nop_pendB",  32'(pendB), 32'd0);

    // Back-to-back stream with a gap in valid
    for (int i = 1; i <= 7; i++) begin
      if (i == 4) idle(5'd3, 5'd4);
      cycle(i <= 6, 2'b01, 5'(i), 32'h1000 + i, 32'h0, 5'(i), 5'(i - 1));
      if (i > 1 && i != 4) begin
        check("stream_add",   32'(writeAdd), 32'(i - 1));
        check("stream_ready", 32'(req_ready), 32'd1);
      end
    end

    // Return-address writes back to back
    for (int i = 0; i <= 5; i++) begin
      cycle(i < 5, 2'b11, 5'(i), 32'h100 + i, 32'h0, 5'd31, 5'd0);
      if (i > 0) begin
        check("ra_kind", 32'(RegWrite), 32'd3);
        check("ra_add",  32'(writeAdd), 32'd31);
        check("ra_data", raDataIn, 32'h100 + i - 1);
      end
    end

    // Asynchronous reset between edges with a write in the slot
    cycle(1'b1, 2'b01, 5'd12, 32'hABCD, 32'h0, 5'd12, 5'd31);
    cycle(1'b1, 2'b11, 5'd0, 32'h77, 32'h0, 5'd12, 5'd31);
    #2;
    req_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_kind",  32'(RegWrite), 32'd0);
    check("arst_data",  writeData, 32'd0);
    check("arst_ra",    raDataIn,  32'd0);
    check("arst_count", 32'(count), 32'd0);
    check("arst_pendA", 32'(pendA), 32'd0);
    check("arst_pendB", 32'(pendB), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 2'b01, 5'd8, 32'h0BAD_CAFE, 32'h0, 5'd8, 5'd0);
    idle(5'd8, 5'd0);
    check("post_kind", 32'(RegWrite), 32'd1);
    check("post_add",  32'(writeAdd), 32'd8);
    check("post_data", writeData, 32'h0BAD_CAFE);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [4:0] ca, cb;
      ca = ($urandom_range(0, 3) == 0) ? 5'(19 + $urandom_range(0, 1)) : 5'($urandom);
      cb = ($urandom_range(0, 3) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      cycle($urandom_range(0, 3) != 0, 2'($urandom),
            ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 7)),
            $urandom, $urandom, ca, cb);
    end
    idle(5'd0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
